// File: rtl/md5_pkg.sv
// Shared MD5 constants, state encoding and helpers for the password authenticator.
package md5_pkg;

   localparam int unsigned WORD_W   = 32;
   localparam int unsigned STEPS    = 64;
   localparam int unsigned IDX_W    = 6;
   localparam int unsigned DIGEST_W = 128;
   localparam int unsigned STAT_W   = 4;
   localparam int unsigned NIB_W    = 4;
   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned MSG_BITS = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [WORD_W-1:0] a;
      logic [WORD_W-1:0] b;
      logic [WORD_W-1:0] c;
      logic [WORD_W-1:0] d;
   } md5_abcd_t;

   localparam md5_abcd_t IV = '{
      a: 32'h67452301,
      b: 32'hefcdab89,
      c: 32'h98badcfe,
      d: 32'h10325476
   };

   localparam logic [STAT_W-1:0] STAT_BUSY  = 4'h0;
   localparam logic [STAT_W-1:0] STAT_GRANT = 4'h1;
   localparam logic [STAT_W-1:0] STAT_DENY  = 4'h2;

   localparam logic [WORD_W-1:0] K_TAB [STEPS] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };

   // Shift amounts repeat every four steps within a round: index is {round, step[1:0]}.
   localparam logic [4:0] S_TAB [16] = '{
      5'd7, 5'd12, 5'd17, 5'd22,
      5'd5, 5'd9,  5'd14, 5'd20,
      5'd4, 5'd11, 5'd16, 5'd23,
      5'd6, 5'd10, 5'd15, 5'd21
   };

   function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x,
                                              input logic [4:0]        s);
      logic [2*WORD_W-1:0] t;
      t = {x, x} << s;
      return t[2*WORD_W-1:WORD_W];
   endfunction

   function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

endpackage

// File: rtl/md5_step.sv
// Combinational single MD5 step: applies round function, constant, rotate and lane shuffle.
module md5_step
   import md5_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic [WORD_W-1:0] c,
   input  logic [WORD_W-1:0] d,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] w_g,
   output logic [WORD_W-1:0] a_c,
   output logic [WORD_W-1:0] b_c,
   output logic [WORD_W-1:0] c_c,
   output logic [WORD_W-1:0] d_c
);

   logic [WORD_W-1:0] f;
   logic [WORD_W-1:0] sum;

   always_comb begin
      f = '0;
      case (idx[5:4])
         2'd0:    f = (b & c) | (~b & d);
         2'd1:    f = (b & d) | (c & ~d);
         2'd2:    f = b ^ c ^ d;
         default: f = c ^ (b | ~d);
      endcase
      sum = a + f + K_TAB[idx] + w_g;
      a_c = d;
      b_c = b + rotl(sum, S_TAB[{idx[5:4], idx[1:0]}]);
      c_c = b;
      d_c = c;
   end

endmodule

// File: rtl/control.sv
// Single-block MD5 password authenticator: hashes one nibble-derived byte and
// compares the digest against a stored reference to grant or deny access.
module control
   import md5_pkg::*;
#(
   parameter logic [127:0] EXPECTED_HASH = 128'h68b329da9893e34099c7d8ad5cb9c940
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NIB_W-1:0] s_axis_tdata,
   output logic [STAT_W-1:0] out,
   output logic             s_axis_ready,
   output logic             m_axis_tdata
);

   state_t              state;
   state_t              state_nxt;
   logic [IDX_W-1:0]    round_cnt;
   md5_abcd_t           abcd;
   logic [BYTE_W-1:0]   msg_byte;
   logic [DIGEST_W-1:0] digest;

   logic [3:0]          g_c;
   logic [WORD_W-1:0]   w_g_c;
   logic [WORD_W-1:0]   a_nxt_c;
   logic [WORD_W-1:0]   b_nxt_c;
   logic [WORD_W-1:0]   c_nxt_c;
   logic [WORD_W-1:0]   d_nxt_c;
   logic [DIGEST_W-1:0] digest_c;
   logic                match_c;
   logic                ready_nxt;
   logic                grant_nxt;
   logic [STAT_W-1:0]   out_nxt;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: one capture cycle, 64 rounds, one finalize cycle, then park
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  state_nxt = ST_ROUND;
         ST_ROUND: if (round_cnt == IDX_W'(STEPS - 1)) state_nxt = ST_FINAL;
         ST_FINAL: state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_DONE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Message word select; the padded block has only two non-zero words
   always_comb begin
      g_c = round_cnt[3:0];
      case (round_cnt[5:4])
         2'd1:    g_c = 4'(round_cnt[3:0] * 4'd5 + 4'd1);
         2'd2:    g_c = 4'(round_cnt[3:0] * 4'd3 + 4'd5);
         2'd3:    g_c = 4'(round_cnt[3:0] * 4'd7);
         default: g_c = round_cnt[3:0];
      endcase
      w_g_c = '0;
      if (g_c == 4'd0)       w_g_c = {16'h0000, 8'h80, msg_byte};
      else if (g_c == 4'd14) w_g_c = WORD_W'(MSG_BITS);
   end

   md5_step u_step (
      .a   (abcd.a),
      .b   (abcd.b),
      .c   (abcd.c),
      .d   (abcd.d),
      .idx (round_cnt),
      .w_g (w_g_c),
      .a_c (a_nxt_c),
      .b_c (b_nxt_c),
      .c_c (c_nxt_c),
      .d_c (d_nxt_c)
   );

   // Final chaining add and little-endian to byte-string reordering
   always_comb begin
      digest_c = {bswap32(IV.a + abcd.a), bswap32(IV.b + abcd.b),
                  bswap32(IV.c + abcd.c), bswap32(IV.d + abcd.d)};
      match_c  = (state == ST_FINAL) ? (digest_c == EXPECTED_HASH)
                                     : (digest   == EXPECTED_HASH);
   end

   // Output decode, registered below
   always_comb begin
      ready_nxt = 1'b0;
      grant_nxt = 1'b0;
      out_nxt   = STAT_BUSY;
      if (state == ST_FINAL || state == ST_DONE) begin
         ready_nxt = 1'b1;
         grant_nxt = match_c;
         out_nxt   = match_c ? STAT_GRANT : STAT_DENY;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s_axis_ready <= 1'b0;
         m_axis_tdata <= 1'b0;
         out          <= STAT_BUSY;
      end else begin
         s_axis_ready <= ready_nxt;
         m_axis_tdata <= grant_nxt;
         out          <= out_nxt;
      end
   end

   // Datapath: capture, round iteration and digest latch
   always_ff @(posedge clk) begin
      if (!reset) begin
         round_cnt <= '0;
         abcd      <= '0;
         msg_byte  <= '0;
         digest    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               msg_byte  <= {4'b0000, s_axis_tdata};
               abcd      <= IV;
               round_cnt <= '0;
            end
            ST_ROUND: begin
               abcd      <= '{a: a_nxt_c, b: b_nxt_c, c: c_nxt_c, d: d_nxt_c};
               round_cnt <= round_cnt + IDX_W'(1);
            end
            ST_FINAL: digest <= digest_c;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control.sv
// Self-checking bench for the MD5 authenticator: directed test-plan runs plus
// randomized nibbles checked against a software MD5 model.
module tb_control;

   localparam logic [127:0] HASH_0A = 128'h68b329da9893e34099c7d8ad5cb9c940;
   localparam logic [127:0] HASH_00 = 128'h93b885adfe0da089cdf634904fd59f71;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] s_axis_tdata = 4'h0;
   logic [3:0] out;
   logic       s_axis_ready;
   logic       m_axis_tdata;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] k_tab [64];
   int          sh [4][4];

   control dut (
      .clk          (clk),
      .reset        (reset),
      .s_axis_tdata (s_axis_tdata),
      .out          (out),
      .s_axis_ready (s_axis_ready),
      .m_axis_tdata (m_axis_tdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] bswap(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   // Textbook MD5 of a single byte message
   function automatic logic [127:0] md5_ref(input logic [7:0] m);
      logic [31:0] w [16];
      logic [31:0] a, b, c, d, f, t;
      int g, s;
      for (int j = 0; j < 16; j++) w[j] = '0;
      w[0]  = {16'h0000, 8'h80, m};
      w[14] = 32'd8;
      a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
      for (int i = 0; i < 64; i++) begin
         if (i < 16)      begin f = (b & c) | (~b & d); g = i;                end
         else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
         else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
         else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
         s = sh[i / 16][i % 4];
         t = a + f + k_tab[i] + w[g];
         a = d;
         d = c;
         c = b;
         b = b + ((t << s) | (t >> (32 - s)));
      end
      return {bswap(a + 32'h67452301), bswap(b + 32'hefcdab89),
              bswap(c + 32'h98badcfe), bswap(d + 32'h10325476)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold reset two cycles with the given nibble presented, check cleared outputs
   task automatic start(input logic [3:0] nib);
      reset = 1'b0;
      s_axis_tdata = nib;
      tick();
      tick();
      check("rst_ready", 128'(s_axis_ready), 128'(1'b0));
      check("rst_grant", 128'(m_axis_tdata), 128'(1'b0));
      check("rst_out",   128'(out),          128'(4'h0));
   endtask

   // Release reset and follow the 66-cycle run; optionally disturb the input after capture
   task automatic follow(input int scramble, input logic [127:0] exp_d);
      logic exp_g;
      exp_g = (exp_d == HASH_0A);
      reset = 1'b1;
      for (int c = 1; c <= 66; c++) begin
         tick();
         if (scramble == 1) s_axis_tdata = 4'b0011;
         else if (scramble == 2) s_axis_tdata = 4'($urandom);
         if (c < 66) begin
            check($sformatf("busy_c%0d", c), 128'({s_axis_ready, m_axis_tdata, out}), 128'(6'b0));
         end else begin
            check("done_ready", 128'(s_axis_ready), 128'(1'b1));
            check("done_grant", 128'(m_axis_tdata), 128'(exp_g));
            check("done_out",   128'(out),          128'(exp_g ? 4'h1 : 4'h2));
            check("digest",     dut.digest,         exp_d);
         end
      end
   endtask

   initial begin
      logic [3:0]   nib;
      logic [127:0] exp_d;
      real          r;

      for (int i = 0; i < 64; i++) begin
         r = $sin(real'(i + 1));
         if (r < 0.0) r = -r;
         k_tab[i] = 32'(longint'($floor(r * 4294967296.0)));
      end
      sh = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

      // Granting password, then long DONE hold, then reset out of DONE
      start(4'b1010);
      follow(0, HASH_0A);
      for (int c = 0; c < 100; c++) begin
         tick();
         s_axis_tdata = 4'($urandom);
         check("hold", 128'({s_axis_ready, m_axis_tdata, out}), 128'({1'b1, 1'b1, 4'h1}));
      end
      check("hold_digest", dut.digest, HASH_0A);
      reset = 1'b0;
      tick();
      check("rst_from_done", 128'({s_axis_ready, m_axis_tdata, out}), 128'(6'b0));

      // Denied password
      start(4'b0000);
      follow(0, HASH_00);

      // Input toggled after capture must not matter
      start(4'b1010);
      follow(1, HASH_0A);

      // Abort at round 30, then a fresh granting run
      start(4'b0101);
      reset = 1'b1;
      repeat (31) tick();
      reset = 1'b0;
      s_axis_tdata = 4'b1010;
      tick();
      check("abort_out", 128'({s_axis_ready, m_axis_tdata, out}), 128'(6'b0));
      follow(0, HASH_0A);

      // Randomized nibbles against the software model
      for (int n = 0; n < 10; n++) begin
         nib = 4'($urandom);
         exp_d = md5_ref({4'h0, nib});
         start(nib);
         follow(2, exp_d);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
